// File: rtl/wb_trace_buffer_if.sv
// wb_trace_buffer_if: control, write-back snoop and readout signals for wb_trace_buffer.
// The master side (CPU/bench) drives the snoop and control inputs.
// The slave side (the trace buffer) drives the readout and status outputs.
interface wb_trace_buffer_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  // Control
  logic          arm;
  logic          abort;
  logic [31:0]   trig_pc;

  // Write-back snoop
  logic [31:0]   wb_pc;
  logic          rf_wen;
  logic [4:0]    rf_wdest;
  logic [31:0]   rf_wdata;
  logic [3:0]    dm_wen;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_wdata;

  // Readout
  logic [AW-1:0] rd_idx;
  logic          rd_valid;
  logic          rd_kind;
  logic [31:0]   rd_pc;
  logic [4:0]    rd_tag;
  logic [31:0]   rd_addr;
  logic [31:0]   rd_data;

  // Status
  logic [1:0]    state;
  logic [AW:0]   count;
  logic [AW-1:0] trig_idx;
  logic          collide;

  modport master (
    output arm, abort, trig_pc, wb_pc, rf_wen, rf_wdest, rf_wdata, dm_wen, dm_addr, dm_wdata,
           rd_idx,
    input  rd_valid, rd_kind, rd_pc, rd_tag, rd_addr, rd_data, state, count, trig_idx, collide
  );

  modport slave (
    input  arm, abort, trig_pc, wb_pc, rf_wen, rf_wdest, rf_wdata, dm_wen, dm_addr, dm_wdata,
           rd_idx,
    output rd_valid, rd_kind, rd_pc, rd_tag, rd_addr, rd_data, state, count, trig_idx, collide
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: commit-trace capture for the multi-cycle CPU.
// Snoops register-file and data-memory write-back events into a circular buffer, stops
// POST_CNT events after a PC trigger, and reads entries back by age index (0 = oldest).
// Optional feature macro: TRACE_DM_EN enables capture of data-memory write events; without
// it only rf events are stored and rd_kind, rd_addr and collide are tied to 0.
module wb_trace_buffer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned POST_CNT = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  wb_trace_buffer_if.slave trace_io
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CountMax = (AW + 1)'(DEPTH);
  localparam logic [AW:0] PostMax  = (AW + 1)'(POST_CNT);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPre  = 2'd1,
    StPost = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q;
  logic [AW-1:0] trig_phys_q;
  logic [AW:0]   post_q;
  logic          collide_q;

  // Entry storage; deliberately not reset.
  logic [31:0]   pc_mem   [DEPTH];
  logic [4:0]    tag_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
`ifdef TRACE_DM_EN
  logic          kind_mem [DEPTH];
  logic [31:0]   addr_mem [DEPTH];
`endif

  logic          rd_valid_q;
  logic          rd_kind_q;
  logic [31:0]   rd_pc_q;
  logic [4:0]    rd_tag_q;
  logic [31:0]   rd_addr_q;
  logic [31:0]   rd_data_q;

  logic          rf_ev;
  logic          dm_ev;
  logic          capture_on;
  logic          rec;
  logic          is_trig;
  logic          ev_kind;
  logic [4:0]    ev_tag;
  logic [31:0]   ev_addr;
  logic [31:0]   ev_data;
  logic [AW-1:0] wr_ptr_d;
  logic [AW:0]   count_d;
  logic [AW-1:0] oldest_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_in_range;

  // Event decode: rf wins over dm when both fire in the same cycle.
  always_comb begin
    rf_ev      = trace_io.rf_wen;
`ifdef TRACE_DM_EN
    dm_ev      = |trace_io.dm_wen;
`else
    dm_ev      = 1'b0;
`endif
    // In POST, the cycle where the post counter has reached its limit is the hand-off to DONE.
    capture_on = (state_q == StPre) || ((state_q == StPost) && (post_q != PostMax));
    rec        = capture_on && (rf_ev || dm_ev) && !trace_io.arm && !trace_io.abort;
    is_trig    = (state_q == StPre) && (trace_io.wb_pc == trace_io.trig_pc);
    ev_kind    = !rf_ev && dm_ev;
    ev_tag     = rf_ev ? trace_io.rf_wdest : {1'b0, trace_io.dm_wen};
    ev_addr    = rf_ev ? 32'h0 : trace_io.dm_addr;
    ev_data    = rf_ev ? trace_io.rf_wdata : trace_io.dm_wdata;
    wr_ptr_d   = wr_ptr_q + 1'b1;
    count_d    = (count_q == CountMax) ? count_q : count_q + 1'b1;
    // count == DEPTH has zero low bits, so the full buffer starts at wr_ptr.
    oldest_ptr  = wr_ptr_q - count_q[AW-1:0];
    rd_ptr      = oldest_ptr + trace_io.rd_idx;
    rd_in_range = ({1'b0, trace_io.rd_idx} < count_q);
  end

`ifndef TRACE_DM_EN
  logic unused_dm;
  assign unused_dm = ^{trace_io.dm_wen, trace_io.dm_addr, trace_io.dm_wdata, ev_kind, ev_addr};
`endif

  // Capture FSM and pointers; reset beats arm, arm beats abort.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      trig_phys_q <= '0;
      post_q      <= '0;
      collide_q   <= 1'b0;
    end else if (trace_io.arm) begin
      state_q     <= StPre;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      trig_phys_q <= '0;
      post_q      <= '0;
      collide_q   <= 1'b0;
    end else if (trace_io.abort) begin
      state_q <= StIdle;
    end else begin
      if (rec) begin
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
        if (rf_ev && dm_ev) begin
          collide_q <= 1'b1;
        end
      end
      unique case (state_q)
        StPre: begin
          if (rec && is_trig) begin
            trig_phys_q <= wr_ptr_q;
            post_q      <= '0;
            state_q     <= StPost;
          end
        end
        StPost: begin
          if (post_q == PostMax) begin
            state_q <= StDone;
          end else if (rec) begin
            post_q <= post_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Entry write at the current write pointer.
  always_ff @(posedge clk_i) begin
    if (rec) begin
      pc_mem[wr_ptr_q]   <= trace_io.wb_pc;
      tag_mem[wr_ptr_q]  <= ev_tag;
      data_mem[wr_ptr_q] <= ev_data;
`ifdef TRACE_DM_EN
      kind_mem[wr_ptr_q] <= ev_kind;
      addr_mem[wr_ptr_q] <= ev_addr;
`endif
    end
  end

  // Registered readout; a same-cycle write to the entry returns the old contents.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_valid_q <= 1'b0;
      rd_kind_q  <= 1'b0;
      rd_pc_q    <= '0;
      rd_tag_q   <= '0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_in_range;
      rd_pc_q    <= rd_in_range ? pc_mem[rd_ptr]   : '0;
      rd_tag_q   <= rd_in_range ? tag_mem[rd_ptr]  : '0;
      rd_data_q  <= rd_in_range ? data_mem[rd_ptr] : '0;
`ifdef TRACE_DM_EN
      rd_kind_q  <= rd_in_range ? kind_mem[rd_ptr] : 1'b0;
      rd_addr_q  <= rd_in_range ? addr_mem[rd_ptr] : '0;
`else
      rd_kind_q  <= 1'b0;
      rd_addr_q  <= '0;
`endif
    end
  end

  assign trace_io.rd_valid = rd_valid_q;
  assign trace_io.rd_kind  = rd_kind_q;
  assign trace_io.rd_pc    = rd_pc_q;
  assign trace_io.rd_tag   = rd_tag_q;
  assign trace_io.rd_addr  = rd_addr_q;
  assign trace_io.rd_data  = rd_data_q;
  assign trace_io.state    = state_q;
  assign trace_io.count    = count_q;
  assign trace_io.trig_idx = trig_phys_q - oldest_ptr;
  assign trace_io.collide  = collide_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed self-checking bench for wb_trace_buffer (DEPTH=16, POST_CNT=8).
module tb_wb_trace_buffer;
  logic clk_i;
  logic reset_i;
  int   total;
  int   passed;

  wb_trace_buffer_if #(.DEPTH(16)) bus ();

  wb_trace_buffer #(
    .DEPTH   (16),
    .POST_CNT(8)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .trace_io(bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One rf write-back event lasting one cycle.
  task automatic rf_ev(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] data);
    bus.wb_pc    = pc;
    bus.rf_wen   = 1'b1;
    bus.rf_wdest = dest;
    bus.rf_wdata = data;
    tick();
    bus.rf_wen   = 1'b0;
  endtask

  task automatic do_arm(input logic [31:0] tpc);
    bus.trig_pc = tpc;
    bus.arm     = 1'b1;
    tick();
    bus.arm     = 1'b0;
  endtask

  task automatic read_idx(input logic [3:0] idx);
    bus.rd_idx = idx;
    tick();
  endtask

  initial begin
    total        = 0;
    passed       = 0;
    reset_i      = 1'b1;
    bus.arm      = 1'b0;
    bus.abort    = 1'b0;
    bus.trig_pc  = '0;
    bus.wb_pc    = '0;
    bus.rf_wen   = 1'b0;
    bus.rf_wdest = '0;
    bus.rf_wdata = '0;
    bus.dm_wen   = '0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    bus.rd_idx   = '0;
    tick();
    tick();
    reset_i = 1'b0;

    // Reset state
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_trig_idx", 32'(bus.trig_idx), 32'd0);
    chk("rst_collide", 32'(bus.collide), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);

    // Basic capture with trigger at 0x10
    do_arm(32'h10);
    chk("arm_state", 32'(bus.state), 32'd1);
    rf_ev(32'h0, 5'd16, 32'h0000_AAAA);
    rf_ev(32'h4, 5'd8, 32'hFFFF_5555);
    rf_ev(32'h8, 5'd9, 32'h0000_AAAB);
    rf_ev(32'hC, 5'd10, 32'h0000_AAAC);
    rf_ev(32'h10, 5'd1, 32'h1);
    chk("trig_state", 32'(bus.state), 32'd2);
    for (int i = 0; i < 8; i++) rf_ev(32'h14 + 32'(4 * i), 5'(i + 2), 32'(i));
    tick();
    chk("t1_state", 32'(bus.state), 32'd3);
    chk("t1_count", 32'(bus.count), 32'd13);
    chk("t1_trig_idx", 32'(bus.trig_idx), 32'd4);
    read_idx(4'd0);
    chk("t1_rd0_valid", 32'(bus.rd_valid), 32'd1);
    chk("t1_rd0_pc", bus.rd_pc, 32'h0);
    chk("t1_rd0_tag", 32'(bus.rd_tag), 32'd16);
    chk("t1_rd0_data", bus.rd_data, 32'h0000_AAAA);
    chk("t1_rd0_kind", 32'(bus.rd_kind), 32'd0);
    read_idx(4'd3);
    chk("t1_rd3_tag", 32'(bus.rd_tag), 32'd10);
    chk("t1_rd3_data", bus.rd_data, 32'h0000_AAAC);

    // Readout latency 0 -> 1
    read_idx(4'd0);
    bus.rd_idx = 4'd1;
    #2;
    chk("lat_hold_pc", bus.rd_pc, 32'h0);
    tick();
    chk("lat_new_pc", bus.rd_pc, 32'h4);
    chk("lat_new_data", bus.rd_data, 32'hFFFF_5555);
    read_idx(4'd13);
    chk("oob_valid", 32'(bus.rd_valid), 32'd0);
    chk("oob_data", bus.rd_data, 32'd0);
    chk("oob_pc", bus.rd_pc, 32'd0);

    // DONE ignores events
    rf_ev(32'h80, 5'd3, 32'h3);
    chk("done_count", 32'(bus.count), 32'd13);

    // Wrap-around
    do_arm(32'h100);
    chk("wrap_arm_count", 32'(bus.count), 32'd0);
    for (int k = 0; k < 20; k++) rf_ev(32'(4 * k), 5'd4, 32'(k));
    chk("wrap_pre_count", 32'(bus.count), 32'd16);
    chk("wrap_pre_state", 32'(bus.state), 32'd1);
    rf_ev(32'h100, 5'd5, 32'h55);
    for (int i = 0; i < 8; i++) rf_ev(32'h200 + 32'(4 * i), 5'd6, 32'(i));
    tick();
    chk("wrap_state", 32'(bus.state), 32'd3);
    chk("wrap_count", 32'(bus.count), 32'd16);
    chk("wrap_trig_idx", 32'(bus.trig_idx), 32'd7);
    read_idx(4'd0);
    chk("wrap_oldest_pc", bus.rd_pc, 32'h34);
    read_idx(4'd7);
    chk("wrap_trig_pc", bus.rd_pc, 32'h100);
    read_idx(4'd15);
    chk("wrap_newest_pc", bus.rd_pc, 32'h21C);

    // Same-cycle rf and dm write
    do_arm(32'hFFFF_FFF0);
    bus.dm_wen   = 4'hF;
    bus.dm_addr  = 32'h20;
    bus.dm_wdata = 32'h1234;
    rf_ev(32'h40, 5'd2, 32'h10);
    bus.dm_wen   = 4'h0;
    chk("col_count", 32'(bus.count), 32'd1);
    read_idx(4'd0);
    chk("col_kind", 32'(bus.rd_kind), 32'd0);
    chk("col_tag", 32'(bus.rd_tag), 32'd2);
    chk("col_data", bus.rd_data, 32'h10);
    chk("col_addr", bus.rd_addr, 32'h0);
    // dm-only event
    bus.wb_pc    = 32'h44;
    bus.dm_wen   = 4'h3;
    bus.dm_addr  = 32'h88;
    bus.dm_wdata = 32'hCAFE;
    tick();
    bus.dm_wen   = 4'h0;
    read_idx(4'd1);
`ifdef TRACE_DM_EN
    chk("col_collide", 32'(bus.collide), 32'd1);
    chk("dm_count", 32'(bus.count), 32'd2);
    chk("dm_kind", 32'(bus.rd_kind), 32'd1);
    chk("dm_tag", 32'(bus.rd_tag), 32'd3);
    chk("dm_addr", bus.rd_addr, 32'h88);
    chk("dm_data", bus.rd_data, 32'hCAFE);
`else
    chk("col_collide", 32'(bus.collide), 32'd0);
    chk("dm_count", 32'(bus.count), 32'd1);
    chk("dm_valid", 32'(bus.rd_valid), 32'd0);
`endif

    // Abort during POST after 3 post-trigger events
    do_arm(32'h8);
    for (int i = 0; i < 6; i++) rf_ev(32'(4 * i), 5'd7, 32'(i));
    chk("ab_post_state", 32'(bus.state), 32'd2);
    chk("ab_post_count", 32'(bus.count), 32'd6);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab_state", 32'(bus.state), 32'd0);
    chk("ab_count", 32'(bus.count), 32'd6);
    chk("ab_trig_idx", 32'(bus.trig_idx), 32'd2);
    rf_ev(32'h50, 5'd7, 32'h7);
    chk("ab_ignore_count", 32'(bus.count), 32'd6);
    bus.abort = 1'b1;
    do_arm(32'h8);
    bus.abort = 1'b0;
    chk("ab_rearm_state", 32'(bus.state), 32'd1);
    chk("ab_rearm_count", 32'(bus.count), 32'd0);

    // Reset in POST
    do_arm(32'h0);
    rf_ev(32'h0, 5'd1, 32'h1);
    rf_ev(32'h4, 5'd2, 32'h2);
    bus.rd_idx = 4'd0;
    tick();
    chk("rs_pre_state", 32'(bus.state), 32'd2);
    chk("rs_pre_valid", 32'(bus.rd_valid), 32'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("rs_state", 32'(bus.state), 32'd0);
    chk("rs_count", 32'(bus.count), 32'd0);
    chk("rs_valid", 32'(bus.rd_valid), 32'd0);
    reset_i = 1'b1;
    do_arm(32'h0);
    reset_i = 1'b0;
    chk("rs_arm_state", 32'(bus.state), 32'd0);
    tick();
    chk("rs_arm_state2", 32'(bus.state), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end
endmodule
